// File: rtl/data_memory_pkg.sv
// Shared definitions for the clocked data memory and the load/store unit.
package data_memory_pkg;

  localparam int unsigned DM_DATA_WIDTH = 8;
  localparam int unsigned DM_ADDR_WIDTH = 8;
  localparam int unsigned DM_DEPTH      = 256;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_READY = 1'b1
  } dm_state_e;

endpackage

// File: rtl/data_memory_array.sv
// Raw word storage: one clocked write port and a registered read port.
module data_memory_array #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic                  rzero_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read data holds between reads; rzero_i substitutes 0 for rejected addresses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_sync.sv
// Clocked data memory with valid/ready requests and a post-reset clear sweep.
// Optional address bounds check: define DATA_MEMORY_BOUNDS_CHECK_EN.
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = DM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  read_not_write,
  input  logic [ADDR_WIDTH-1:0] address_in_bus,
  input  logic [DATA_WIDTH-1:0] data_in_bus,
  output logic [DATA_WIDTH-1:0] data_out_bus,
  output logic                  rsp_valid,
  output logic                  err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  dm_state_e        state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             rsp_valid_q;

  logic             accept;
  logic             in_range;
  logic             clearing;
  logic             rd_acc;
  logic             wr_acc;
  logic [IDX_W-1:0] idx;

  logic             arr_we;
  logic [IDX_W-1:0] arr_waddr;
  logic [DATA_WIDTH-1:0] arr_wdata;

  assign idx = address_in_bus[IDX_W-1:0];

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  logic err_q;

  assign in_range = ({1'b0, address_in_bus} < DEPTH_EXT);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && !in_range;
    end
  end

  assign err = err_q;
`else
  logic unused_addr;

  assign in_range    = 1'b1;
  assign unused_addr = ^address_in_bus;
  assign err         = 1'b0;
`endif

  // rst is folded in here so a request coinciding with reset never reaches the array.
  always_comb begin
    accept   = (state_q == DM_READY) && req_valid && !rst;
    clearing = (state_q == DM_CLEAR) && !rst;
    rd_acc   = accept && read_not_write;
    wr_acc   = accept && !read_not_write && in_range;
  end

  always_comb begin
    arr_we    = clearing || wr_acc;
    arr_waddr = clearing ? cnt_q : idx;
    arr_wdata = clearing ? '0 : data_in_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DM_CLEAR;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      rsp_valid_q <= rd_acc;
      case (state_q)
        DM_CLEAR: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_q <= DM_READY;
          end
        end
        DM_READY: begin
          state_q <= DM_READY;
        end
        default: begin
          state_q <= DM_CLEAR;
        end
      endcase
    end
  end

  assign req_ready = (state_q == DM_READY);
  assign rsp_valid = rsp_valid_q;

  data_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (arr_we),
    .waddr_i(arr_waddr),
    .wdata_i(arr_wdata),
    .re_i   (rd_acc),
    .rzero_i(!in_range),
    .raddr_i(idx),
    .rdata_o(data_out_bus)
  );

endmodule

// File: tb/tb_data_memory_sync.sv
// Self-checking bench for data_memory_sync: vector table plus reset/clear sequences.
module tb_data_memory_sync;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  localparam int unsigned DEPTH = 200;
`else
  localparam int unsigned DEPTH = 256;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          read_not_write;
  logic [AW-1:0] address_in_bus;
  logic [DW-1:0] data_in_bus;
  logic [DW-1:0] data_out_bus;
  logic          rsp_valid;
  logic          err;

  typedef struct {
    logic          rd;
    logic [DW-1:0] data;
    logic          er;
  } exp_t;

  typedef struct {
    logic          rnw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  exp_t   q[$];
  exp_t   mon_e;
  vec_t   vecs[14];
  int     checks   = 0;
  int     failures = 0;
  logic [AW-1:0] top_addr;

  data_memory_sync #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .read_not_write(read_not_write),
    .address_in_bus(address_in_bus),
    .data_in_bus   (data_in_bus),
    .data_out_bus  (data_out_bus),
    .rsp_valid     (rsp_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Response monitor: each accepted read (or erroring request) was queued before its edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, mon_e.rd});
      if (mon_e.rd) chk("rd_data", {24'b0, data_out_bus}, {24'b0, mon_e.data});
      chk("err", {31'b0, err}, {31'b0, mon_e.er});
    end else begin
      chk("rsp_idle", {31'b0, rsp_valid}, 32'd0);
      chk("err_idle", {31'b0, err}, 32'd0);
    end
  end

  task automatic issue(input logic rnw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] ex, input logic er);
    req_valid      = 1'b1;
    read_not_write = rnw;
    address_in_bus = a;
    data_in_bus    = d;
    if (rnw || er) q.push_back('{rd: rnw, data: ex, er: er});
    @(negedge clk);
  endtask

  task automatic idle();
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  // Call at a negedge right after releasing rst; counts edges until req_ready rises.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready && n < int'(DEPTH) + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, n, DEPTH);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    top_addr = AW'(DEPTH - 1);
    vecs[0]  = '{rnw: 1'b1, addr: 8'h10,    wdata: 8'h00, exp: 8'h00};
    vecs[1]  = '{rnw: 1'b0, addr: 8'h10,    wdata: 8'h50, exp: 8'h00};
    vecs[2]  = '{rnw: 1'b1, addr: 8'h10,    wdata: 8'h00, exp: 8'h50};
    vecs[3]  = '{rnw: 1'b0, addr: 8'h10,    wdata: 8'h30, exp: 8'h00};
    vecs[4]  = '{rnw: 1'b1, addr: 8'h10,    wdata: 8'h00, exp: 8'h30};
    vecs[5]  = '{rnw: 1'b0, addr: 8'h20,    wdata: 8'hAA, exp: 8'h00};
    vecs[6]  = '{rnw: 1'b1, addr: 8'h20,    wdata: 8'h00, exp: 8'hAA};
    vecs[7]  = '{rnw: 1'b0, addr: 8'h21,    wdata: 8'h55, exp: 8'h00};
    vecs[8]  = '{rnw: 1'b1, addr: 8'h21,    wdata: 8'h00, exp: 8'h55};
    vecs[9]  = '{rnw: 1'b0, addr: top_addr, wdata: 8'h5A, exp: 8'h00};
    vecs[10] = '{rnw: 1'b0, addr: 8'h00,    wdata: 8'hA5, exp: 8'h00};
    vecs[11] = '{rnw: 1'b1, addr: top_addr, wdata: 8'h00, exp: 8'h5A};
    vecs[12] = '{rnw: 1'b1, addr: 8'h00,    wdata: 8'h00, exp: 8'hA5};
    vecs[13] = '{rnw: 1'b1, addr: 8'h20,    wdata: 8'h00, exp: 8'hAA};

    rst            = 1'b1;
    req_valid      = 1'b0;
    read_not_write = 1'b0;
    address_in_bus = '0;
    data_in_bus    = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'b0, req_ready}, 32'd0);
    chk("reset_rsp", {31'b0, rsp_valid}, 32'd0);
    chk("reset_err", {31'b0, err}, 32'd0);
    chk("reset_data", {24'b0, data_out_bus}, 32'd0);

    rst = 1'b0;
    wait_ready("clear_latency");

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].rnw, vecs[i].addr, vecs[i].wdata, vecs[i].exp, 1'b0);
    end
    idle();
    chk("data_hold_idle", {24'b0, data_out_bus}, 32'hAA);
    issue(1'b0, 8'h10, 8'h99, 8'h00, 1'b0);
    idle();
    chk("data_hold_write", {24'b0, data_out_bus}, 32'hAA);

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    issue(1'b0, 8'h48, 8'h11, 8'h00, 1'b0);
    issue(1'b0, 8'hC8, 8'h77, 8'h00, 1'b1);
    issue(1'b1, 8'hC8, 8'h00, 8'h00, 1'b1);
    issue(1'b1, 8'h48, 8'h00, 8'h11, 1'b0);
    idle();
`endif

    // Reset in READY, then reset again 10 edges into the clear sweep.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("midclear_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midclear_rst_ready", {31'b0, req_ready}, 32'd0);
    rst = 1'b0;
    wait_ready("clear_restart");
    issue(1'b1, 8'h10, 8'h00, 8'h00, 1'b0);
    issue(1'b1, 8'h21, 8'h00, 8'h00, 1'b0);

    // Read presented together with reset is dropped; monitor expects no response.
    issue(1'b0, 8'h22, 8'h3C, 8'h00, 1'b0);
    req_valid      = 1'b1;
    read_not_write = 1'b1;
    address_in_bus = 8'h22;
    rst            = 1'b1;
    @(negedge clk);
    chk("drop_data", {24'b0, data_out_bus}, 32'd0);
    rst            = 1'b0;
    req_valid      = 1'b1;
    read_not_write = 1'b0;
    address_in_bus = 8'h03;
    data_in_bus    = 8'hEE;
    wait_ready("clear_after_drop");
    issue(1'b1, 8'h22, 8'h00, 8'h00, 1'b0);
    issue(1'b1, 8'h03, 8'h00, 8'h00, 1'b0);
    idle();
    idle();
    chk("queue_drained", q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
